mac_result_buf: RTL and testbench

MAC_RESULT_BUF -- requirements
Module: mac_result_buf

---
 rtl/mac_result_buf.sv | 131 +++++++++++++
 tb/tb_mac_result_buf.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_buf.sv
// rtl/mac_result_buf.sv - result FIFO between a systolic MAC array and its consumer, with frame tagging
module mac_result_buf #(
  parameter int W     = 8,
  parameter int N     = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       clr_i,
  input  logic                       result_v_i,
  input  logic [W-1:0]               result_i,
  output logic                       out_v_o,
  output logic [W-1:0]               out_data_o,
  output logic                       out_last_o,
  input  logic                       out_rdy_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       frame_done_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FN = N * N;
  localparam int CW = (FN > 1) ? $clog2(FN) : 1;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(FN - 1);

  // Entry storage: bit W is the frame-last tag, bits W-1:0 the result.
  logic [W:0]      mem [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            frame_done_q, frame_done_d;
  logic            overflow_q, overflow_d;

  logic            push_try;
  logic            push_ok;
  logic            push_drop;
  logic            pop;
  logic            cnt_last;
  logic            not_empty;
  logic            mem_we;

  assign not_empty = (level_q != '0);
  assign cnt_last  = (cnt_q == CNT_LAST);

  // Next-state for pointers, occupancy, frame counter and flags; clear overrides everything.
  always_comb begin
    push_try     = ena && result_v_i;
    pop          = ena && not_empty && out_rdy_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok      = push_try && ((level_q != LVL_FULL) || pop);
    push_drop    = push_try && !push_ok;
    mem_we       = push_ok && !clr_i;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push_ok, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    // Dropped results still advance the counter so later frames stay aligned.
    if (push_try) begin
      cnt_d        = cnt_last ? '0 : cnt_q + CW'(1);
      frame_done_d = cnt_last;
    end

    if (push_drop) begin
      overflow_d = 1'b1;
    end

    if (clr_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      cnt_d        = '0;
      frame_done_d = 1'b0;
      overflow_d   = 1'b0;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Entry write; data storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= {cnt_last, result_i};
    end
  end

  assign out_v_o      = not_empty;
  assign out_data_o   = mem[rd_ptr_q][W-1:0];
  assign out_last_o   = not_empty && mem[rd_ptr_q][W];
  assign level_o      = level_q;
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_mac_result_buf.sv
// tb/tb_mac_result_buf.sv - directed self-checking bench for mac_result_buf
module tb_mac_result_buf;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       clr_i;
  logic       result_v_i;
  logic [7:0] result_i;
  logic       out_v_o;
  logic [7:0] out_data_o;
  logic       out_last_o;
  logic       out_rdy_i;
  logic [2:0] level_o;
  logic       frame_done_o;
  logic       overflow_o;

  int n_pass  = 0;
  int n_total = 0;

  mac_result_buf #(.W(8), .N(2), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .clr_i        (clr_i),
    .result_v_i   (result_v_i),
    .result_i     (result_i),
    .out_v_o      (out_v_o),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .out_rdy_i    (out_rdy_i),
    .level_o      (level_o),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [7:0] vals [4];
    rst_n = 1'b0; ena = 1'b0; clr_i = 1'b0; result_v_i = 1'b0; result_i = 8'h00; out_rdy_i = 1'b0;
    tick(); tick();
    chk("rst_level", level_o, 0);
    chk("rst_out_v", out_v_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_fdone", frame_done_o, 0);
    chk("rst_ovf", overflow_o, 0);

    // Fill one frame with consumer stalled
    rst_n = 1'b1; ena = 1'b1;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      result_v_i = 1'b1; result_i = vals[i];
      tick();
      chk("fill_level", level_o, i + 1);
      chk("fill_fdone", frame_done_o, (i == 3) ? 1 : 0);
      chk("fill_head", out_data_o, 8'h11);
      chk("fill_out_v", out_v_o, 1);
    end
    result_v_i = 1'b0;
    tick();
    chk("fill_fdone_once", frame_done_o, 0);
    chk("fill_hold", out_data_o, 8'h11);
    out_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", out_data_o, vals[i]);
      chk("drain_last", out_last_o, (i == 3) ? 1 : 0);
      tick();
    end
    chk("drain_level", level_o, 0);
    chk("drain_out_v", out_v_o, 0);

    // Fill again, then drop while full
    out_rdy_i = 1'b0;
    vals[0] = 8'hA0; vals[1] = 8'hA1; vals[2] = 8'hA2; vals[3] = 8'hA3;
    for (int i = 0; i < 4; i++) begin
      result_v_i = 1'b1; result_i = vals[i];
      tick();
    end
    chk("full_level", level_o, 4);
    result_i = 8'h55;
    tick();
    chk("drop_level", level_o, 4);
    chk("drop_ovf", overflow_o, 1);
    chk("drop_head", out_data_o, 8'hA0);
    result_i = 8'h66; tick();
    chk("drop66_fdone", frame_done_o, 0);
    result_i = 8'h77; tick();
    chk("drop77_fdone", frame_done_o, 0);
    result_i = 8'h88; tick();
    chk("drop88_fdone", frame_done_o, 1);
    chk("drop88_level", level_o, 4);

    // Push into a full FIFO while popping
    result_i = 8'h99; out_rdy_i = 1'b1;
    tick();
    chk("pp_level", level_o, 4);
    chk("pp_ovf", overflow_o, 1);
    chk("pp_fdone", frame_done_o, 0);
    result_v_i = 1'b0;
    vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3; vals[3] = 8'h99;
    for (int i = 0; i < 4; i++) begin
      chk("pp_data", out_data_o, vals[i]);
      chk("pp_last", out_last_o, (i == 2) ? 1 : 0);
      tick();
    end
    chk("pp_empty", level_o, 0);

    // Soft clear resets overflow and counter (counter currently 1)
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("clr_ovf", overflow_o, 0);
    out_rdy_i = 1'b0;
    result_v_i = 1'b1; result_i = 8'hB1; tick();
    result_i = 8'hB2; tick();
    chk("clr_pre_level", level_o, 2);
    clr_i = 1'b1; result_i = 8'hCC; tick();
    clr_i = 1'b0;
    chk("clr_level", level_o, 0);
    chk("clr_out_v", out_v_o, 0);
    chk("clr_ovf2", overflow_o, 0);
    chk("clr_fdone", frame_done_o, 0);
    vals[0] = 8'hC0; vals[1] = 8'hC1; vals[2] = 8'hC2; vals[3] = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      result_i = vals[i];
      tick();
      chk("clr_cnt_fdone", frame_done_o, (i == 3) ? 1 : 0);
    end
    result_v_i = 1'b0; out_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("clr_data", out_data_o, vals[i]);
      chk("clr_last", out_last_o, (i == 3) ? 1 : 0);
      tick();
    end

    // Enable low freezes everything
    out_rdy_i = 1'b0;
    result_v_i = 1'b1; result_i = 8'hD0; tick();
    ena = 1'b0; result_i = 8'hEE; out_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ena_level", level_o, 1);
      chk("ena_fdone", frame_done_o, 0);
      chk("ena_head", out_data_o, 8'hD0);
    end
    ena = 1'b1; out_rdy_i = 1'b0;
    vals[0] = 8'hD0; vals[1] = 8'hD1; vals[2] = 8'hD2; vals[3] = 8'hD3;
    for (int i = 1; i < 4; i++) begin
      result_i = vals[i];
      tick();
      chk("ena_cnt_fdone", frame_done_o, (i == 3) ? 1 : 0);
    end
    chk("ena_full", level_o, 4);
    result_v_i = 1'b0; out_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ena_data", out_data_o, vals[i]);
      chk("ena_last", out_last_o, (i == 3) ? 1 : 0);
      tick();
    end

    // Streaming: push and pop every cycle
    for (int i = 0; i < 12; i++) begin
      result_v_i = 1'b1; result_i = 8'(8'h40 + i);
      tick();
      chk("stream_level", level_o, 1);
      chk("stream_data", out_data_o, 8'h40 + i);
      chk("stream_last", out_last_o, ((i % 4) == 3) ? 1 : 0);
    end
    result_v_i = 1'b0;
    tick();
    chk("stream_level_end", level_o, 0);
    chk("stream_ovf", overflow_o, 0);

    // Reset mid-frame discards contents and realigns the counter
    out_rdy_i = 1'b0;
    result_v_i = 1'b1; result_i = 8'hE0; tick();
    result_i = 8'hE1; tick();
    rst_n = 1'b0; result_v_i = 1'b0; tick();
    rst_n = 1'b1;
    chk("midrst_level", level_o, 0);
    chk("midrst_out_v", out_v_o, 0);
    for (int i = 0; i < 4; i++) begin
      result_v_i = 1'b1; result_i = 8'(8'hF0 + i);
      tick();
      chk("midrst_fdone", frame_done_o, (i == 3) ? 1 : 0);
    end
    result_v_i = 1'b0; out_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_data", out_data_o, 8'hF0 + i);
      chk("midrst_last", out_last_o, (i == 3) ? 1 : 0);
      tick();
    end
    chk("midrst_empty", level_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
